// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller that pops single bytes from a FIFO and offers them on valid/ready
// Ports: clk/rst (sync, active-high); en gates new reads; nostock is the FIFO empty flag;
//        rd is the one-cycle pop strobe; fifodata is the FIFO registered dout (valid the cycle after rd);
//        odata/ovalid/ordy form the downstream handshake; busy is high outside IDLE;
//        bytecnt counts accepted bytes when FIFO_DRAIN_CNT_EN is defined, else it is tied to 0.
module fifo_drain #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          nostock,
  input  logic [DW-1:0] fifodata,
  output logic          rd,
  output logic [DW-1:0] odata,
  output logic          ovalid,
  input  logic          ordy,
  output logic          busy,
  output logic [CW-1:0] bytecnt
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3;
  logic [1:0] state, nxt;
  logic start;
  assign start = en && !nostock;
  // HOLD exits straight to REQ when more data is available, so a steady drain costs three cycles per byte
  always_comb
    nxt = state == IDLE ? (start ? REQ : IDLE) :
          state == REQ  ? WAIT :
          state == WAIT ? HOLD :
          !ordy         ? HOLD :
          start         ? REQ  : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      odata <= '0;
    end else begin
      state <= nxt;
      if (state == WAIT) odata <= fifodata;
    end
  assign rd     = state == REQ;
  assign ovalid = state == HOLD;
  assign busy   = state != IDLE;
`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk)
    bytecnt <= rst ? '0 : bytecnt + CW'(state == HOLD && ordy);
`else
  assign bytecnt = '0;
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: randomized and directed bench for fifo_drain against a FIFO model and byte scoreboard
module tb_fifo_drain;
  logic        clk = 0;
  logic        rst, en, nostock, ordy;
  logic [7:0]  fifodata;
  logic        rd, ovalid, busy;
  logic [7:0]  odata;
  logic [15:0] bytecnt;

  fifo_drain #(.DW(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .nostock(nostock), .fifodata(fifodata),
    .rd(rd), .odata(odata), .ovalid(ovalid), .ordy(ordy), .busy(busy), .bytecnt(bytecnt)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] sb[$];
  int checks = 0, failures = 0;
  int cyc = 0, rd_cnt = 0, acc_cnt = 0, last_rd = -1;
  int base_rd, base_acc;
  logic burst = 0, prev_rd = 0, prev_ov = 0, prev_acc = 0;
  logic [7:0] prev_od = 0;
  logic [15:0] cnt_model = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] cnt_exp();
`ifdef FIFO_DRAIN_CNT_EN
    return cnt_model;
`else
    return 16'd0;
`endif
  endfunction

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    sb.push_back(b);
    nostock = 0;
  endtask

  task automatic tick();
    logic r, a;
    chk("rd_while_valid", rd & ovalid, 0);
    chk("rd_width", rd & prev_rd, 0);
    chk("busy", busy, rd | ovalid | prev_rd);
    chk("bytecnt", bytecnt, cnt_exp());
    if (ovalid && prev_ov && !prev_acc) chk("hold_stable", odata, prev_od);
    if (rd && burst && last_rd >= 0) chk("rd_gap", cyc - last_rd, 3);
    if (rd) last_rd = cyc;
    a = ovalid && ordy;
    if (a) begin
      if (sb.size() == 0) chk("unexpected_byte", 1, 0);
      else chk("data", odata, sb.pop_front());
    end
    r = rd;
    prev_rd = rd; prev_ov = ovalid; prev_acc = a; prev_od = odata;
    @(posedge clk); #1;
    cyc++;
    if (r) begin
      rd_cnt++;
      chk("overread", q.size() == 0, 0);
      if (q.size() > 0) fifodata = q.pop_front();
    end
    if (a && !rst) begin acc_cnt++; cnt_model++; end
    nostock = q.size() == 0;
  endtask

  task automatic drain_until(input int left);
    int n = 0;
    while (!(sb.size() == left && !busy) && n < 300) begin tick(); n++; end
    if (n >= 300) chk("drain_timeout", 1, 0);
  endtask

  task automatic wait_ovalid();
    int n = 0;
    while (!ovalid && n < 50) begin tick(); n++; end
    if (!ovalid) chk("ovalid_timeout", 1, 0);
  endtask

  initial begin
    rst = 1; en = 1; ordy = 1; nostock = 1; fifodata = 0;
    push(8'h11);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rd", rd, 0);
      chk("rst_ovalid", ovalid, 0);
      chk("rst_odata", odata, 0);
      chk("rst_bytecnt", bytecnt, 0);
      tick();
    end
    rst = 0;
    chk("rd_at_release", rd, 0);
    tick();
    chk("first_rd", rd, 1);
    drain_until(0);

    base_rd = rd_cnt;
    push(8'hA5);
    chk("lat_n", rd, 0);
    tick();
    chk("lat_n1_rd", rd, 1);
    tick();
    tick();
    chk("lat_n3_ovalid", ovalid, 1);
    chk("lat_n3_odata", odata, 8'hA5);
    repeat (6) tick();
    chk("single_rd_count", rd_cnt - base_rd, 1);

    base_rd = rd_cnt; base_acc = acc_cnt;
    for (int i = 1; i <= 10; i++) push(8'(i));
    burst = 1; last_rd = -1;
    drain_until(0);
    burst = 0;
    chk("burst_rd_count", rd_cnt - base_rd, 10);
    chk("burst_acc_count", acc_cnt - base_acc, 10);
    chk("burst_nostock", nostock, 1);

    ordy = 0; base_rd = rd_cnt; base_acc = acc_cnt;
    push(8'h21); push(8'h22); push(8'h23);
    repeat (20) tick();
    chk("bp_ovalid", ovalid, 1);
    chk("bp_odata", odata, 8'h21);
    chk("bp_rd_count", rd_cnt - base_rd, 1);
    ordy = 1;
    drain_until(0);
    chk("bp_acc_count", acc_cnt - base_acc, 3);

    en = 0; base_rd = rd_cnt; base_acc = acc_cnt;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    repeat (10) tick();
    chk("en_block_rd", rd_cnt - base_rd, 0);
    en = 1;
    tick();
    chk("en_rd", rd, 1);
    tick();
    en = 0;
    drain_until(4);
    repeat (5) tick();
    chk("en_drop_rd", rd_cnt - base_rd, 1);
    chk("en_drop_acc", acc_cnt - base_acc, 1);
    chk("en_drop_left", q.size(), 4);
    en = 1;
    drain_until(0);

    ordy = 0;
    push(8'h3C);
    wait_ovalid();
    chk("hold_odata", odata, 8'h3C);
    rst = 1;
    tick();
    q.delete(); sb.delete(); nostock = 1; cnt_model = 0; prev_rd = 0; prev_ov = 0;
    chk("rsthold_ovalid", ovalid, 0);
    chk("rsthold_odata", odata, 0);
    chk("rsthold_busy", busy, 0);
    chk("rsthold_bytecnt", bytecnt, 0);
    rst = 0; ordy = 1;
    tick();

    base_acc = acc_cnt;
    begin
      int pushed = 0;
      for (int i = 0; i < 400; i++) begin
        ordy = $urandom_range(0, 9) < 7;
        en = $urandom_range(0, 9) < 8;
        if (q.size() < 10 && $urandom_range(0, 9) < 3) begin
          push(8'($urandom));
          pushed++;
        end
        tick();
      end
      en = 1; ordy = 1;
      drain_until(0);
      chk("rand_acc_count", acc_cnt - base_acc, pushed);
    end
    chk("final_bytecnt", bytecnt, cnt_exp());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
